// File: rtl/execute_stage_mc_if.sv
// Handshake/data bundle between the DX register, the EX stage and the MEM stage.
//   DX side -> EX : flush, in_valid, operands, forwarding selects, decode fields, alu_op
//   EX -> DX side : in_ready, busy
//   EX -> MEM     : out_valid, ALUresult, outB, regWriteSel, negF, zeroF
// master: pipeline/control side driving ops; slave: the execute stage.
interface execute_stage_mc_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned REGW  = 5
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic [WIDTH-1:0] mem_fwd;
  logic [WIDTH-1:0] wb_fwd;
  logic [1:0]       forwardA;
  logic [1:0]       forwardB;
  logic [WIDTH-1:0] immediate;
  logic             ALUSrc;
  logic             regDst;
  logic [REGW-1:0]  rt_DX;
  logic [REGW-1:0]  rd_DX;
  logic [3:0]       alu_op;
  logic             out_valid;
  logic [WIDTH-1:0] ALUresult;
  logic [WIDTH-1:0] outB;
  logic [REGW-1:0]  regWriteSel;
  logic             negF;
  logic             zeroF;
  logic             busy;

  modport master (
    output flush, in_valid, rs_data, rt_data, mem_fwd, wb_fwd, forwardA, forwardB,
           immediate, ALUSrc, regDst, rt_DX, rd_DX, alu_op,
    input  in_ready, out_valid, ALUresult, outB, regWriteSel, negF, zeroF, busy
  );

  modport slave (
    input  flush, in_valid, rs_data, rt_data, mem_fwd, wb_fwd, forwardA, forwardB,
           immediate, ALUSrc, regDst, rt_DX, rd_DX, alu_op,
    output in_ready, out_valid, ALUresult, outB, regWriteSel, negF, zeroF, busy
  );
endinterface

// File: rtl/execute_stage_mc.sv
// Pipeline EX stage with valid/ready handshake, synchronous flush, zero/negative flags and an
// iterative shift-add unsigned multiplier writing internal HI/LO.
//   clock_i : rising-edge clock
//   reset_i : synchronous, active-high reset
//   ex_if   : execute_stage_mc_if.slave (DX inputs, in_ready/busy, EX/MEM registered outputs)
module execute_stage_mc #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned REGW  = 5
) (
  input logic               clock_i,
  input logic               reset_i,
  execute_stage_mc_if.slave ex_if
);
  localparam int unsigned SHW = $clog2(WIDTH);

  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpSub  = 4'd1;
  localparam logic [3:0] OpAnd  = 4'd2;
  localparam logic [3:0] OpOr   = 4'd3;
  localparam logic [3:0] OpXor  = 4'd4;
  localparam logic [3:0] OpSlt  = 4'd5;
  localparam logic [3:0] OpSll  = 4'd6;
  localparam logic [3:0] OpSrl  = 4'd7;
  localparam logic [3:0] OpMult = 4'd8;
  localparam logic [3:0] OpMflo = 4'd9;
  localparam logic [3:0] OpMfhi = 4'd10;

  typedef enum logic [0:0] {StIdle, StMul} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d, acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d, outb_q, outb_d;
  logic [REGW-1:0]    sel_q, sel_d;
  logic               neg_q, neg_d, zero_q, zero_d, valid_q, valid_d;

  logic [WIDTH-1:0]   op_a, fwd_b, op_b, alu_res;
  logic [2*WIDTH-1:0] acc_next;
  logic               accept;

  function automatic logic [WIDTH-1:0] fwd_sel(input logic [1:0] sel, input logic [WIDTH-1:0] reg_v,
                                               input logic [WIDTH-1:0] mem_v,
                                               input logic [WIDTH-1:0] wb_v);
    logic [WIDTH-1:0] r;
    unique case (sel)
      2'b00:   r = reg_v;
      2'b01:   r = mem_v;
      2'b10:   r = wb_v;
      default: r = '0;
    endcase
    return r;
  endfunction

  assign op_a  = fwd_sel(ex_if.forwardA, ex_if.rs_data, ex_if.mem_fwd, ex_if.wb_fwd);
  assign fwd_b = fwd_sel(ex_if.forwardB, ex_if.rt_data, ex_if.mem_fwd, ex_if.wb_fwd);
  assign op_b  = ex_if.ALUSrc ? ex_if.immediate : fwd_b;

  assign ex_if.in_ready = (state_q == StIdle);
  assign ex_if.busy     = (state_q == StMul);
  assign accept         = ex_if.in_valid & ex_if.in_ready & ~ex_if.flush;

  always_comb begin
    alu_res = '0;
    case (ex_if.alu_op)
      OpAdd:   alu_res = op_a + op_b;
      OpSub:   alu_res = op_a - op_b;
      OpAnd:   alu_res = op_a & op_b;
      OpOr:    alu_res = op_a | op_b;
      OpXor:   alu_res = op_a ^ op_b;
      OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OpSll:   alu_res = op_a << op_b[SHW-1:0];
      OpSrl:   alu_res = op_a >> op_b[SHW-1:0];
      OpMflo:  alu_res = lo_q;
      OpMfhi:  alu_res = hi_q;
      default: alu_res = '0;
    endcase
  end

  // One shift-add step: multiplicand moves left, multiplier right, LSB gates the add.
  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    outb_d   = outb_q;
    sel_d    = sel_q;
    neg_d    = neg_q;
    zero_d   = zero_q;
    valid_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (ex_if.alu_op == OpMult) begin
            state_d  = StMul;
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, op_a};
            mplier_d = op_b;
          end else begin
            valid_d  = 1'b1;
            result_d = alu_res;
            outb_d   = fwd_b;
            sel_d    = ex_if.regDst ? ex_if.rd_DX : ex_if.rt_DX;
            neg_d    = alu_res[WIDTH-1];
            zero_d   = (alu_res == '0);
          end
        end
      end
      StMul: begin
        if (ex_if.flush) begin
          // Abort leaves HI/LO and the output registers untouched.
          state_d = StIdle;
        end else begin
          acc_d    = acc_next;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == SHW'(WIDTH - 1)) begin
            state_d      = StIdle;
            {hi_d, lo_d} = acc_next;
            result_d     = acc_next[WIDTH-1:0];
            sel_d        = '0;
            valid_d      = 1'b1;
            neg_d        = acc_next[WIDTH-1];
            zero_d       = (acc_next[WIDTH-1:0] == '0);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      hi_q     <= '0;
      lo_q     <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      outb_q   <= '0;
      sel_q    <= '0;
      neg_q    <= 1'b0;
      zero_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      outb_q   <= outb_d;
      sel_q    <= sel_d;
      neg_q    <= neg_d;
      zero_q   <= zero_d;
      valid_q  <= valid_d;
    end
  end

  assign ex_if.out_valid   = valid_q;
  assign ex_if.ALUresult   = result_q;
  assign ex_if.outB        = outb_q;
  assign ex_if.regWriteSel = sel_q;
  assign ex_if.negF        = neg_q;
  assign ex_if.zeroF       = zero_q;
endmodule
